// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_pkg
// Description : Shared RV32 core definitions: opcodes, NOP and fetch states.
// Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;

    localparam logic [6:0] r_type    = 7'b0110011;
    localparam logic [6:0] s_type    = 7'b0100011;
    localparam logic [6:0] i_type    = 7'b0010011;
    localparam logic [6:0] l_type    = 7'b0000011;
    localparam logic [6:0] b_type    = 7'b1100011;
    localparam logic [6:0] jal_type  = 7'b1101111;
    localparam logic [6:0] jalr_type = 7'b1100111;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_REQ  = 2'd1,
        FETCH_WAIT = 2'd2,
        FETCH_HOLD = 2'd3
    } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Single-outstanding instruction fetch front-end with redirect.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import core_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);

    fetch_state_e    r_state;
    logic [XLEN-1:0] r_pc;
    logic            r_kill;
    logic            r_req_valid;
    logic            r_inst_valid;
    logic [31:0]     r_inst;
    logic [XLEN-1:0] r_inst_pc;

    logic [XLEN-1:0] w_redirect_pc;

    assign w_redirect_pc  = {redirect_pc[XLEN-1:2], 2'b00};

    assign imem_req_valid = r_req_valid;
    assign imem_req_addr  = r_pc;
    assign inst_valid     = r_inst_valid;
    assign inst           = r_inst;
    assign inst_pc        = r_inst_pc;

    // Redirect is evaluated first in every state; r_kill marks the single
    // response still owed by memory for a request made before the redirect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= FETCH_IDLE;
            r_pc         <= RESET_PC;
            r_kill       <= 1'b0;
            r_req_valid  <= 1'b0;
            r_inst_valid <= 1'b0;
            r_inst       <= NOP_INST;
            r_inst_pc    <= '0;
        end else begin
            case (r_state)
                FETCH_IDLE: begin
                    if (redirect_valid) begin
                        r_pc <= w_redirect_pc;
                    end
                    r_req_valid <= 1'b1;
                    r_state     <= FETCH_REQ;
                end
                FETCH_REQ: begin
                    if (redirect_valid) begin
                        r_pc <= w_redirect_pc;
                    end
                    if (imem_req_ready) begin
                        r_req_valid <= 1'b0;
                        r_state     <= FETCH_WAIT;
                        if (redirect_valid) begin
                            r_kill <= 1'b1;
                        end
                    end
                end
                FETCH_WAIT: begin
                    if (redirect_valid) begin
                        r_pc <= w_redirect_pc;
                        if (imem_rsp_valid) begin
                            r_kill      <= 1'b0;
                            r_req_valid <= 1'b1;
                            r_state     <= FETCH_REQ;
                        end else begin
                            r_kill <= 1'b1;
                        end
                    end else if (imem_rsp_valid) begin
                        if (r_kill) begin
                            r_kill      <= 1'b0;
                            r_req_valid <= 1'b1;
                            r_state     <= FETCH_REQ;
                        end else begin
                            r_inst       <= imem_rsp_data;
                            r_inst_pc    <= r_pc;
                            r_inst_valid <= 1'b1;
                            r_pc         <= r_pc + XLEN'(4);
                            r_state      <= FETCH_HOLD;
                        end
                    end
                end
                FETCH_HOLD: begin
                    if (redirect_valid || inst_ready) begin
                        if (redirect_valid) begin
                            r_pc <= w_redirect_pc;
                        end
                        r_inst_valid <= 1'b0;
                        r_req_valid  <= 1'b1;
                        r_state      <= FETCH_REQ;
                    end
                end
                default: begin
                    r_state <= FETCH_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed + random bench for fetch_unit against a PC-stream model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    always #5 clk = ~clk;

    fetch_unit #(
        .XLEN     (32),
        .RESET_PC (RST_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: the architectural PC the next delivered instruction must carry
    logic [31:0] exp_pc;
    logic [31:0] req_q[$];
    logic [31:0] deliv_q[$];
    int          deliv_cyc[$];
    int          cyc = 0;

    // Memory model and stimulus policy
    logic        mem_busy = 1'b0;
    logic [31:0] mem_addr;
    int          mem_wait;
    int          lat_min, lat_max, ready_pct, ir_pct, rd_pct, spur_pct;

    // Outputs as seen during the cycle leading into the next rising edge
    logic        s_req_valid, s_ivalid;
    logic [31:0] s_addr, s_inst, s_ipc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic sample();
        s_req_valid = imem_req_valid;
        s_addr      = imem_req_addr;
        s_ivalid    = inst_valid;
        s_inst      = inst;
        s_ipc       = inst_pc;
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (!rst) begin
            if (s_req_valid && imem_req_ready) begin
                chk("req_addr", s_addr, exp_pc);
                req_q.push_back(s_addr);
                mem_busy = 1'b1;
                mem_addr = s_addr;
                mem_wait = $urandom_range(lat_max, lat_min);
            end
            if (s_ivalid && inst_ready) begin
                chk("deliv_pc", s_ipc, exp_pc);
                chk("deliv_inst", s_inst, mem_word(exp_pc));
                deliv_q.push_back(s_ipc);
                deliv_cyc.push_back(cyc);
                exp_pc = exp_pc + 32'd4;
            end
            if (redirect_valid) begin
                exp_pc = {redirect_pc[31:2], 2'b00};
            end
        end
        sample();
        chk("no_req_in_hold", {31'b0, s_req_valid & s_ivalid}, 32'd0);
        if (s_req_valid) begin
            chk("addr_align", {30'b0, s_addr[1:0]}, 32'd0);
        end
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
        if (mem_busy) begin
            if (mem_wait == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(mem_addr);
                mem_busy       = 1'b0;
            end else begin
                mem_wait--;
            end
        end else if ($urandom_range(99) < spur_pct) begin
            imem_rsp_valid = 1'b1;
        end
        imem_req_ready = !mem_busy && ($urandom_range(99) < ready_pct);
        inst_ready     = $urandom_range(99) < ir_pct;
        redirect_valid = $urandom_range(99) < rd_pct;
        redirect_pc    = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                                  : $urandom;
    endtask

    task automatic policy(input int lmin, input int lmax, input int rdy, input int ir,
                          input int rd, input int sp);
        lat_min = lmin; lat_max = lmax; ready_pct = rdy;
        ir_pct  = ir;   rd_pct  = rd;   spur_pct  = sp;
    endtask

    initial begin
        int          n;
        logic [31:0] h_pc, h_inst;
        logic        seen;

        rst = 1'b1;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        policy(0, 0, 100, 100, 0, 0);
        exp_pc = RST_PC;

        // Reset hold for three cycles
        repeat (3) begin
            @(negedge clk);
            chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
            chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
            chk("rst_inst", inst, 32'h0000_0013);
            chk("rst_inst_pc", inst_pc, 32'd0);
        end
        rst = 1'b0;
        #1;
        chk("release_req_valid", {31'b0, imem_req_valid}, 32'd0);
        sample();
        tick();
        chk("first_req_valid", {31'b0, s_req_valid}, 32'd1);
        chk("first_req_addr", s_addr, RST_PC);

        // Streaming with a 1-cycle memory and no backpressure
        for (int k = 0; k < 20 && deliv_q.size() < 3; k++) tick();
        chk("stream_count", deliv_q.size() >= 3, 32'd1);
        if (deliv_q.size() >= 3) begin
            chk("stream_pc0", deliv_q[0], 32'h100);
            chk("stream_pc1", deliv_q[1], 32'h104);
            chk("stream_pc2", deliv_q[2], 32'h108);
            chk("stream_gap01", deliv_cyc[1] - deliv_cyc[0], 32'd3);
            chk("stream_gap12", deliv_cyc[2] - deliv_cyc[1], 32'd3);
        end

        // Backpressure in HOLD
        policy(0, 0, 100, 0, 0, 0);
        for (int k = 0; k < 20 && !s_ivalid; k++) tick();
        chk("bp_reach_hold", {31'b0, s_ivalid}, 32'd1);
        h_pc = s_ipc; h_inst = s_inst; n = req_q.size();
        repeat (5) begin
            tick();
            chk("bp_ivalid", {31'b0, s_ivalid}, 32'd1);
            chk("bp_inst", s_inst, h_inst);
            chk("bp_inst_pc", s_ipc, h_pc);
            chk("bp_no_req", {31'b0, s_req_valid}, 32'd0);
        end
        policy(0, 0, 100, 100, 0, 0);
        for (int k = 0; k < 20 && req_q.size() <= n; k++) tick();
        chk("bp_next_req", req_q[$], h_pc + 32'd4);

        // Redirect while the response is still outstanding
        policy(2, 2, 100, 100, 0, 0);
        for (int k = 0; k < 20 && !(mem_busy && mem_wait > 0); k++) tick();
        chk("rw_in_wait", {31'b0, mem_busy}, 32'd1);
        redirect_valid = 1'b1; redirect_pc = 32'h203;
        n = req_q.size(); seen = 1'b0;
        for (int k = 0; k < 20 && req_q.size() <= n; k++) begin
            tick();
            if (s_ivalid) seen = 1'b1;
        end
        chk("rw_no_ivalid", {31'b0, seen}, 32'd0);
        chk("rw_next_req", req_q[$], 32'h200);

        // Redirect in HOLD coinciding with a decode handshake
        policy(0, 0, 100, 0, 0, 0);
        for (int k = 0; k < 20 && !s_ivalid; k++) tick();
        n = deliv_q.size();
        inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h300;
        tick();
        chk("rh_transfer", deliv_q.size(), n + 1);
        chk("rh_ivalid_low", {31'b0, s_ivalid}, 32'd0);
        policy(0, 0, 100, 100, 0, 0);
        n = req_q.size();
        for (int k = 0; k < 20 && req_q.size() <= n; k++) tick();
        chk("rh_next_req", req_q[$], 32'h300);

        // Asynchronous reset while waiting for a response
        policy(3, 3, 100, 100, 0, 0);
        for (int k = 0; k < 20 && !mem_busy; k++) tick();
        #2 rst = 1'b1;
        #1;
        chk("ar_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("ar_inst_valid", {31'b0, inst_valid}, 32'd0);
        chk("ar_inst", inst, 32'h0000_0013);
        chk("ar_req_addr", imem_req_addr, RST_PC);
        exp_pc = RST_PC;
        tick();
        rst = 1'b0;
        n = req_q.size();
        for (int k = 0; k < 20 && req_q.size() <= n; k++) tick();
        chk("ar_next_req", req_q[$], RST_PC);
        n = deliv_q.size();
        for (int k = 0; k < 20 && deliv_q.size() <= n; k++) tick();
        chk("ar_deliv_pc", deliv_q[$], RST_PC);

        // Misaligned redirect to the top of memory, accepted in the same cycle
        policy(0, 0, 100, 100, 0, 0);
        for (int k = 0; k < 20 && !s_req_valid; k++) tick();
        n = req_q.size();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        for (int k = 0; k < 30 && req_q.size() < n + 3; k++) tick();
        chk("wrap_count", req_q.size() >= n + 3, 32'd1);
        if (req_q.size() >= n + 3) begin
            chk("wrap_top", req_q[n + 1], 32'hFFFF_FFFC);
            chk("wrap_zero", req_q[n + 2], 32'h0000_0000);
        end

        // Random traffic: stalls, variable latency, redirects, stray responses
        policy(0, 3, 70, 60, 8, 5);
        n = deliv_q.size();
        repeat (3000) tick();
        chk("rand_progress", deliv_q.size() > n + 50, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
